// File: rtl/pwm_fade_pkg.sv
// Shared types for the PWM fade sequencer: FSM state encoding and level clamping.
package pwm_fade_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RISE    = 3'd1,
      HOLD_HI = 3'd2,
      FALL    = 3'd3,
      HOLD_LO = 3'd4
   } fade_state_t;

   // Saturates a requested level at full-on (2**res).
   function automatic logic [31:0] clamp_level(input logic [31:0] lvl, input int unsigned res);
      logic [31:0] full;
      full = 32'd1 << res;
      return (lvl > full) ? full : lvl;
   endfunction

endpackage

// File: rtl/fade_step_tick.sv
// Step-rate divider: counts 0..div while enabled and pulses tick on the terminal count.
module fade_step_tick #(
   parameter int TICK_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [TICK_W-1:0] div,
   output logic              tick
);

   logic [TICK_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = en && (cnt_q == div);
      cnt_d = cnt_q + TICK_W'(1);
      if (!en || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Drives the PWM duty through RISE / HOLD_HI / FALL / HOLD_LO, once or looping.
// Optional FADE_GAMMA_EN adds a registered squaring stage on the duty output.
module pwm_fade_sequencer
   import pwm_fade_pkg::*;
#(
   parameter int R      = 8,
   parameter int TICK_W = 24,
   parameter int HOLD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              cont,
   input  logic [R:0]        level_lo,
   input  logic [R:0]        level_hi,
   input  logic [TICK_W-1:0] step_div,
   input  logic [HOLD_W-1:0] hold_ticks,
   output logic [R:0]        duty,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state_o
);

   localparam int LW = R + 1;

   fade_state_t       state_q, state_d;
   logic [R:0]        lvl_q, lvl_d, lo_q, lo_d, hi_q, hi_d;
   logic [R:0]        lo_clamped, hi_clamped, lvl_inc, lvl_dec;
   logic [TICK_W-1:0] div_q, div_d;
   logic [HOLD_W-1:0] hold_ticks_q, hold_ticks_d, hold_q, hold_d;
   logic              cont_q, cont_d, done_q, done_d;
   logic              tick, flat, hold_end;

   assign lo_clamped = LW'(clamp_level(32'(level_lo), R));
   assign hi_clamped = LW'(clamp_level(32'(level_hi), R));
   assign lvl_inc    = lvl_q + LW'(1);
   assign lvl_dec    = lvl_q - LW'(1);
   // A degenerate profile skips the ramps and sits at the floor.
   assign flat       = (lo_q >= hi_q);
   assign hold_end   = tick && (hold_q == hold_ticks_q);

   fade_step_tick #(.TICK_W(TICK_W)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q != IDLE),
      .div  (div_q),
      .tick (tick)
   );

   always_comb begin
      state_d      = state_q;
      lvl_d        = lvl_q;
      lo_d         = lo_q;
      hi_d         = hi_q;
      div_d        = div_q;
      hold_ticks_d = hold_ticks_q;
      cont_d       = cont_q;
      hold_d       = hold_q;
      done_d       = 1'b0;
      if (abort) begin
         state_d = IDLE;
         lvl_d   = '0;
         hold_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  lo_d         = lo_clamped;
                  hi_d         = hi_clamped;
                  div_d        = step_div;
                  hold_ticks_d = hold_ticks;
                  cont_d       = cont;
                  lvl_d        = lo_clamped;
                  hold_d       = '0;
                  state_d      = RISE;
               end
            end
            RISE: begin
               if (flat) begin
                  state_d = HOLD_HI;
               end else if (tick) begin
                  lvl_d = lvl_inc;
                  if (lvl_inc == hi_q) state_d = HOLD_HI;
               end
            end
            HOLD_HI: begin
               if (hold_end) begin
                  hold_d  = '0;
                  state_d = FALL;
               end else if (tick) begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
            FALL: begin
               if (flat) begin
                  state_d = HOLD_LO;
               end else if (tick) begin
                  lvl_d = lvl_dec;
                  if (lvl_dec == lo_q) state_d = HOLD_LO;
               end
            end
            HOLD_LO: begin
               if (hold_end) begin
                  hold_d = '0;
                  if (cont_q) begin
                     state_d = RISE;
                  end else begin
                     state_d = IDLE;
                     lvl_d   = '0;
                     done_d  = 1'b1;
                  end
               end else if (tick) begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               lvl_d   = '0;
               hold_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         lvl_q        <= '0;
         lo_q         <= '0;
         hi_q         <= '0;
         div_q        <= '0;
         hold_ticks_q <= '0;
         cont_q       <= 1'b0;
         hold_q       <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lvl_q        <= lvl_d;
         lo_q         <= lo_d;
         hi_q         <= hi_d;
         div_q        <= div_d;
         hold_ticks_q <= hold_ticks_d;
         cont_q       <= cont_d;
         hold_q       <= hold_d;
         done_q       <= done_d;
      end
   end

`ifdef FADE_GAMMA_EN
   // Squared level keeps full-on at full-on: (2**R)**2 >> R == 2**R.
   logic [2*R+1:0] sq;
   logic [R:0]     duty_q, duty_d;

   always_comb begin
      sq     = lvl_q * lvl_q;
      duty_d = LW'(sq >> R);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         duty_q <= '0;
      end else begin
         duty_q <= duty_d;
      end
   end

   assign duty = duty_q;
`else
   assign duty = lvl_q;
`endif

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Randomized scoreboard bench for pwm_fade_sequencer; expected per-cycle outputs come from
// a segment-based trajectory model and are checked by an independent negedge monitor.
module tb_pwm_fade_sequencer;

   localparam int R      = 8;
   localparam int TICK_W = 24;
   localparam int HOLD_W = 16;
   localparam int FULL   = 1 << R;

   localparam int S_IDLE    = 0;
   localparam int S_RISE    = 1;
   localparam int S_HOLD_HI = 2;
   localparam int S_FALL    = 3;
   localparam int S_HOLD_LO = 4;

   logic              clk = 1'b0;
   logic              rst, start, abort, cont;
   logic [R:0]        level_lo, level_hi, duty;
   logic [TICK_W-1:0] step_div;
   logic [HOLD_W-1:0] hold_ticks;
   logic              busy, done;
   logic [2:0]        state_o;

   always #5 clk = ~clk;

   pwm_fade_sequencer #(.R(R), .TICK_W(TICK_W), .HOLD_W(HOLD_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .cont       (cont),
      .level_lo   (level_lo),
      .level_hi   (level_hi),
      .step_div   (step_div),
      .hold_ticks (hold_ticks),
      .duty       (duty),
      .busy       (busy),
      .done       (done),
      .state_o    (state_o)
   );

   typedef struct {
      int cyc;
      int duty;
      int busy;
      int done;
      int st;
   } exp_t;

   exp_t sbq[$];
   int   traj_lvl[$];
   int   traj_st[$];
   int   cyc     = 0;
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   cur_lvl = 0;
   int   tk      = 0;
   int   run_id  = 0;

   always @(posedge clk) cyc++;

   function automatic int gmap(input int l);
      return (l * l) >> R;
   endfunction

   task automatic chk(input string name, input int c, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, c, got, want);
      end
   endtask

   // Monitor: pops the expectation tagged for the current cycle and compares.
   always @(negedge clk) begin
      exp_t e;
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
         e = sbq.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missed_check cyc=%0d got=none want=cyc%0d", cyc, e.cyc);
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
         e = sbq.pop_front();
         chk("duty",  cyc, int'(duty),    e.duty);
         chk("busy",  cyc, int'(busy),    e.busy);
         chk("done",  cyc, int'(done),    e.done);
         chk("state", cyc, int'(state_o), e.st);
      end
   end

   // Queues what the DUT must show after the next edge, then advances one cycle.
   task automatic step(input int lvl, input int st, input int dn);
      exp_t e;
      e.cyc  = cyc + 1;
`ifdef FADE_GAMMA_EN
      e.duty = rst ? 0 : gmap(cur_lvl);
`else
      e.duty = lvl;
`endif
      e.busy = (st != S_IDLE) ? 1 : 0;
      e.done = dn;
      e.st   = st;
      sbq.push_back(e);
      cur_lvl = lvl;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic scramble_inputs();
      level_lo   = (R+1)'($urandom);
      level_hi   = (R+1)'($urandom);
      step_div   = TICK_W'($urandom);
      hold_ticks = HOLD_W'($urandom);
      cont       = 1'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         abort = ($urandom_range(0, 3) == 0);
         step(0, S_IDLE, 0);
      end
   endtask

   // Spend nt step ticks in one phase; nt==0 means a one-cycle pass-through.
   task automatic emit(input int st, input int nt, input int base, input int dir, input int dv);
      if (nt == 0) begin
         traj_lvl.push_back(base);
         traj_st.push_back(st);
         tk++;
      end else begin
         int seen = 0;
         while (seen < nt) begin
            traj_lvl.push_back(base + dir * seen);
            traj_st.push_back(st);
            if ((tk % (dv + 1)) == dv) seen++;
            tk++;
         end
      end
   endtask

   task automatic do_run(input int lo, input int hi, input int dv, input int hd, input bit ct,
                         input int abort_at, input int rst_at, input bit noisy);
      int    loc, hic, ramp, top, limit;
      string how;
      loc   = (lo > FULL) ? FULL : lo;
      hic   = (hi > FULL) ? FULL : hi;
      ramp  = (loc < hic) ? hic - loc : 0;
      top   = (loc < hic) ? hic : loc;
      limit = (abort_at + 2 > 8) ? abort_at + 2 : 8;
      traj_lvl.delete();
      traj_st.delete();
      tk = 0;
      do begin
         emit(S_RISE,    ramp,   loc, 1,  dv);
         emit(S_HOLD_HI, hd + 1, top, 0,  dv);
         emit(S_FALL,    ramp,   top, -1, dv);
         emit(S_HOLD_LO, hd + 1, loc, 0,  dv);
      end while (ct && traj_lvl.size() < limit);

      level_lo   = (R+1)'(lo);
      level_hi   = (R+1)'(hi);
      step_div   = TICK_W'(dv);
      hold_ticks = HOLD_W'(hd);
      cont       = ct;
      start      = 1'b1;
      step(traj_lvl[0], traj_st[0], 0);
      how = "done";
      for (int i = 0; i < traj_lvl.size(); i++) begin
         if (noisy) begin
            scramble_inputs();
            start = 1'($urandom);
         end
         if (i == rst_at) begin
            rst = 1'b1;
            step(0, S_IDLE, 0);
            rst = 1'b0;
            how = "reset";
            break;
         end
         if (i == abort_at) begin
            abort = 1'b1;
            step(0, S_IDLE, 0);
            how = "abort";
            break;
         end
         if (i + 1 < traj_lvl.size()) step(traj_lvl[i + 1], traj_st[i + 1], 0);
         else                         step(0, S_IDLE, 1);
      end
      run_id++;
      $display("run %0d: lo=%0d hi=%0d div=%0d hold=%0d cont=%0d model_cycles=%0d end=%s",
               run_id, lo, hi, dv, hd, ct, traj_lvl.size(), how);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      cont       = 1'b0;
      level_lo   = '0;
      level_hi   = '0;
      step_div   = '0;
      hold_ticks = '0;
      @(posedge clk);
      #1;
      step(0, S_IDLE, 0);
      step(0, S_IDLE, 0);
      rst = 1'b0;
      idle(2);

      do_run(0, 4, 0, 1, 1'b0, -1, -1, 1'b0);      // short ramp, 12-cycle profile
      idle(2);
      do_run(30, 60, 0, 0, 1'b0, -1, 10, 1'b0);    // reset while duty is 40
      idle(2);
      do_run(10, 12, 9, 0, 1'b0, -1, -1, 1'b1);    // slow steps with ignored restarts
      idle(2);
      do_run(300, 20, 1, 2, 1'b0, -1, -1, 1'b1);   // clamped floor above ceiling
      idle(2);
      do_run(0, 2, 0, 0, 1'b1, 21, -1, 1'b0);      // loop, abort in FALL of 4th pass
      idle(2);
      do_run(128, 128, 0, 0, 1'b0, -1, -1, 1'b0);
      idle(1);
      do_run(256, 256, 0, 1, 1'b0, -1, -1, 1'b0);
      idle(2);
      do_run(0, 256, 0, 0, 1'b0, -1, -1, 1'b0);    // full-range ramp

      for (int r = 0; r < 25; r++) begin
         int lo, hi, dv, hd, ab;
         bit ct;
         lo = $urandom_range(0, 300);
         hi = lo + $urandom_range(0, 12) - 3;
         if (hi < 0) hi = 0;
         dv = $urandom_range(0, 3);
         hd = $urandom_range(0, 3);
         ct = ($urandom_range(0, 2) == 0);
         if (ct)                              ab = $urandom_range(0, 60);
         else if ($urandom_range(0, 3) == 0)  ab = $urandom_range(0, 30);
         else                                 ab = -1;
         do_run(lo, hi, dv, hd, ct, ab, -1, 1'b1);
         idle($urandom_range(1, 4));
      end

      idle(3);
      for (int w = 0; w < 5 && sbq.size() > 0; w++) @(negedge clk);
      if (sbq.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain got=%0d_pending want=0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
